instr_fetch: RTL

Instruction fetch unit. It produces the fetch side of the fetch→decoder issue interface: it keeps the fetch PC and reads instruction bytes through the byte-wide memory arbiter port. It assembles the bytes into 32-bit instructions, buffers them in a small FIFO, and presents them to the decoder under a valid/ready handshake. The fetch path is sequential (PC+4). On ROB `clear`, the FIFO is flushed and fetch redirects to `clear_pc`.

---
 rtl/instr_fetch.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: byte-wide reads assembled into 32-bit words,
// buffered in a small FIFO and issued to the decoder.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IBUF_WIDTH = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic [31:0] clear_pc,
   input  logic        dec_ready,
   output logic        to_dec_valid,
   output logic [31:0] to_dec_pc,
   output logic [31:0] to_dec_instr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_rvalid
);

   localparam int DEPTH = 1 << IBUF_WIDTH;
   localparam logic [IBUF_WIDTH:0] FULL = (IBUF_WIDTH+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

   state_e                state_q, state_d;
   logic [31:0]           fetch_pc_q, fetch_pc_d;
   logic [1:0]            byte_q, byte_d;
   logic [31:0]           asm_q, asm_d, asm_new;
   logic [IBUF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [IBUF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [IBUF_WIDTH:0]   count_q, count_d, cnt_mid;
   logic [31:0]           pc_mem [DEPTH];
   logic [31:0]           ins_mem [DEPTH];
   logic                  push, pop;
   logic                  req_q, req_d;
   logic [31:0]           addr_q, addr_d;
   logic                  valid_q, valid_d;
   logic [31:0]           hd_pc_q, hd_pc_d;
   logic [31:0]           hd_ins_q, hd_ins_d;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      byte_d     = byte_q;
      asm_d      = asm_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      push       = 1'b0;
      pop        = valid_q & dec_ready & ~clear;
      asm_new    = asm_q;
      asm_new[{byte_q, 3'b000} +: 8] = mem_rdata;

      unique case (state_q)
         IDLE: begin
            if (count_q < FULL) begin
               state_d = REQ;
               byte_d  = 2'd0;
            end
         end
         REQ: begin
            if (mem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid) begin
               asm_d = asm_new;
               if (byte_q != 2'd3) begin
                  byte_d  = byte_q + 2'd1;
                  state_d = REQ;
               end else begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = IDLE;
               end
            end
         end
         DRAIN: begin
            if (mem_rvalid) begin
               state_d = IDLE;
               byte_d  = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_mid = count_q - {{IBUF_WIDTH{1'b0}}, pop};
      count_d = cnt_mid + {{IBUF_WIDTH{1'b0}}, push};

      // A byte still in flight must be swallowed before refetching
      if (clear) begin
         push       = 1'b0;
         fetch_pc_d = clear_pc;
         byte_d     = 2'd0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         if ((state_q == WAIT && !mem_rvalid) ||
             (state_q == REQ && mem_gnt) ||
             (state_q == DRAIN && !mem_rvalid))
            state_d = DRAIN;
         else
            state_d = IDLE;
      end

      req_d   = (state_d == REQ);
      addr_d  = req_d ? fetch_pc_d + {30'd0, byte_d} : addr_q;
      valid_d = (count_d != '0);
      if (count_d == '0) begin
         hd_pc_d  = 32'd0;
         hd_ins_d = 32'd0;
      end else if (push && cnt_mid == '0) begin
         hd_pc_d  = fetch_pc_q;
         hd_ins_d = asm_new;
      end else begin
         hd_pc_d  = pc_mem[rd_ptr_d];
         hd_ins_d = ins_mem[rd_ptr_d];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         byte_q     <= 2'd0;
         asm_q      <= 32'd0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         req_q      <= 1'b0;
         addr_q     <= 32'd0;
         valid_q    <= 1'b0;
         hd_pc_q    <= 32'd0;
         hd_ins_q   <= 32'd0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         byte_q     <= byte_d;
         asm_q      <= asm_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         hd_pc_q    <= hd_pc_d;
         hd_ins_q   <= hd_ins_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && rdy_in && push) begin
         pc_mem[wr_ptr_q]  <= fetch_pc_q;
         ins_mem[wr_ptr_q] <= asm_new;
      end
   end

   assign mem_req      = req_q;
   assign mem_addr     = addr_q;
   assign to_dec_valid = valid_q;
   assign to_dec_pc    = hd_pc_q;
   assign to_dec_instr = hd_ins_q;

endmodule
